// File: rtl/mem_io_responder_if.sv
// Bus bundle between the CPU memory controller, the host UART adapter and the
// memory/IO responder.
//  ram_rw_in / ram_addr_in / ram_wdata_in : access presented by the controller
//  ram_rdata_out                          : registered read byte
//  cpu_rdy_out                            : CPU-wide ready, 0 freezes the CPU
//  tx_data_out / tx_valid_out / tx_ready_in : TX byte stream toward the host
//  rx_data_in / rx_valid_in               : RX byte stream from the host
//  rx_overflow_out                        : sticky RX drop flag
// Modport slave is the responder side; master is the driving side.
interface mem_io_responder_if;
    logic        ram_rw_in;
    logic [31:0] ram_addr_in;
    logic [7:0]  ram_wdata_in;
    logic [7:0]  ram_rdata_out;
    logic        cpu_rdy_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        rx_overflow_out;

    modport slave (
        input  ram_rw_in, ram_addr_in, ram_wdata_in, tx_ready_in, rx_data_in, rx_valid_in,
        output ram_rdata_out, cpu_rdy_out, tx_data_out, tx_valid_out, rx_overflow_out
    );

    modport master (
        output ram_rw_in, ram_addr_in, ram_wdata_in, tx_ready_in, rx_data_in, rx_valid_in,
        input  ram_rdata_out, cpu_rdy_out, tx_data_out, tx_valid_out, rx_overflow_out
    );
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the byte-wide CPU memory bus. Holds the program/data RAM and
// an IO window at 0x30000 with a TX byte FIFO toward the host link and an RX
// byte FIFO from it. Freezes the CPU through cpu_rdy_out while TX is full.
// Ports:
//  clk_in  : clock, all state updates on posedge
//  rst_in  : asynchronous active-high reset
//  bus     : mem_io_responder_if.slave (CPU access, TX/RX streams, status)
// IO map (addr[17:16] == 2'b11, offset addr[2:0]):
//  0 write push TX | 0 read pop RX (0x00 if empty) | 4 read status, clears overflow
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter string       INIT_FILE      = ""
) (
    input logic               clk_in,
    input logic               rst_in,
    mem_io_responder_if.slave bus
);
    localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
    localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
    localparam int unsigned TxCntW = TxPtrW + 1;
    localparam int unsigned RxCntW = RxPtrW + 1;

    // Storage (not reset)
    logic [7:0] r_ram    [2**RAM_ADDR_WIDTH];
    logic [7:0] r_tx_mem [TX_DEPTH];
    logic [7:0] r_rx_mem [RX_DEPTH];

    // Control state
    logic [7:0]        r_rdata;
    logic [TxPtrW-1:0] r_tx_wptr, r_tx_rptr;
    logic [TxCntW-1:0] r_tx_count;
    logic [RxPtrW-1:0] r_rx_wptr, r_rx_rptr;
    logic [RxCntW-1:0] r_rx_count;
    logic              r_rx_ovf;

    logic                      w_cpu_rdy;
    logic                      w_sample;
    logic                      w_is_io;
    logic [2:0]                w_off;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                      w_ram_wr;
    logic                      w_rd_any;
    logic                      w_tx_valid, w_tx_full, w_tx_push, w_tx_pop;
    logic                      w_rx_nonempty, w_rx_full, w_rx_pop, w_rx_push, w_rx_drop;
    logic                      w_rd_stat;
    logic [7:0]                w_rd_data;
    logic                      w_unused_addr;

    assign w_tx_full     = (r_tx_count == TxCntW'(TX_DEPTH));
    assign w_tx_valid    = (r_tx_count != '0);
    assign w_rx_full     = (r_rx_count == RxCntW'(RX_DEPTH));
    assign w_rx_nonempty = (r_rx_count != '0);

    // TX can never be pushed while full because the CPU is frozen then.
    assign w_cpu_rdy = ~w_tx_full;
    // Nothing is sampled while reset is held, so a mid-access reset leaves no RAM write behind.
    assign w_sample  = w_cpu_rdy & ~rst_in;

    assign w_is_io       = (bus.ram_addr_in[17:16] == 2'b11);
    assign w_off         = bus.ram_addr_in[2:0];
    assign w_ram_idx     = bus.ram_addr_in[RAM_ADDR_WIDTH-1:0];
    assign w_unused_addr = ^bus.ram_addr_in;

    assign w_ram_wr  = w_sample & bus.ram_rw_in & ~w_is_io;
    assign w_rd_any  = w_sample & ~bus.ram_rw_in;
    assign w_tx_push = w_sample & bus.ram_rw_in & w_is_io & (w_off == 3'd0);
    assign w_tx_pop  = w_tx_valid & bus.tx_ready_in;
    assign w_rx_pop  = w_rd_any & w_is_io & (w_off == 3'd0) & w_rx_nonempty;
    assign w_rd_stat = w_rd_any & w_is_io & (w_off == 3'd4);

    // A full RX FIFO still accepts a byte when the CPU pops on the same edge.
    assign w_rx_push = bus.rx_valid_in & ~rst_in & (~w_rx_full | w_rx_pop);
    assign w_rx_drop = bus.rx_valid_in & w_rx_full & ~w_rx_pop;

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_is_io) begin
            w_rd_data = r_ram[w_ram_idx];
        end else if (w_off == 3'd0) begin
            w_rd_data = w_rx_nonempty ? r_rx_mem[r_rx_rptr] : 8'h00;
        end else if (w_off == 3'd4) begin
            w_rd_data = {5'b0, r_rx_ovf, w_rx_nonempty, w_tx_full};
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_ram_wr) begin
            r_ram[w_ram_idx] <= bus.ram_wdata_in;
        end
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= bus.ram_wdata_in;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= bus.rx_data_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rdata    <= 8'h00;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_rx_ovf   <= 1'b0;
        end else begin
            // Read data only moves on sampled reads; writes and frozen cycles hold it.
            if (w_rd_any) begin
                r_rdata <= w_rd_data;
            end

            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + 1'b1;
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - 1'b1;
            end

            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + 1'b1;
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - 1'b1;
            end

            // A drop on the same edge as a status read wins over the clear.
            if (w_rx_drop) begin
                r_rx_ovf <= 1'b1;
            end else if (w_rd_stat) begin
                r_rx_ovf <= 1'b0;
            end
        end
    end

    assign bus.ram_rdata_out   = r_rdata;
    assign bus.cpu_rdy_out     = w_cpu_rdy;
    assign bus.tx_valid_out    = w_tx_valid;
    assign bus.tx_data_out     = w_tx_valid ? r_tx_mem[r_tx_rptr] : 8'h00;
    assign bus.rx_overflow_out = r_rx_ovf;
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: a table of RAM vectors, hand
// sequences for the FIFO/throttle/reset corners, and a randomized run checked
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_mem_io_responder;
    localparam int unsigned TxDepth = 16;
    localparam int unsigned RxDepth = 16;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_ADDR_WIDTH(17),
        .TX_DEPTH      (TxDepth),
        .RX_DEPTH      (RxDepth),
        .INIT_FILE     ("")
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
        bus.ram_rw_in    = rw;
        bus.ram_addr_in  = addr;
        bus.ram_wdata_in = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 8'h00);
    endtask

    task automatic do_reset();
        idle();
        bus.rx_valid_in = 1'b0;
        bus.rx_data_in  = 8'h00;
        bus.tx_ready_in = 1'b0;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // Table vectors
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        check;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [19];

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] ram_m [int unsigned];
    logic       m_ovf;
    logic [7:0] m_rdata;
    logic       m_known;

    // One clock edge of the model, from the inputs currently on the bus.
    task automatic model_step();
        logic       ready;
        logic       rx_pop;
        logic       clr;
        logic       set;
        logic [2:0] off;
        int unsigned idx;
        ready  = (txq.size() != TxDepth);
        rx_pop = 1'b0;
        clr    = 1'b0;
        set    = 1'b0;
        off    = bus.ram_addr_in[2:0];
        idx    = int'(bus.ram_addr_in & 32'h1_FFFF);
        if (txq.size() != 0 && bus.tx_ready_in) void'(txq.pop_front());
        if (ready) begin
            if (bus.ram_addr_in[17:16] != 2'b11) begin
                if (bus.ram_rw_in) begin
                    ram_m[idx] = bus.ram_wdata_in;
                end else if (ram_m.exists(idx)) begin
                    m_rdata = ram_m[idx];
                    m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
            end else if (bus.ram_rw_in) begin
                if (off == 3'd0) txq.push_back(bus.ram_wdata_in);
            end else begin
                m_known = 1'b1;
                if (off == 3'd0) begin
                    if (rxq.size() != 0) begin
                        m_rdata = rxq[0];
                        rx_pop  = 1'b1;
                    end else begin
                        m_rdata = 8'h00;
                    end
                end else if (off == 3'd4) begin
                    m_rdata = {5'b0, m_ovf, (rxq.size() != 0), 1'b0};
                    clr     = 1'b1;
                end else begin
                    m_rdata = 8'h00;
                end
            end
        end
        if (bus.rx_valid_in) begin
            if (rxq.size() < RxDepth || rx_pop) begin
                if (rx_pop) void'(rxq.pop_front());
                rxq.push_back(bus.rx_data_in);
            end else begin
                set = 1'b1;
            end
        end else if (rx_pop) begin
            void'(rxq.pop_front());
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    initial begin
        idle();
        bus.rx_valid_in = 1'b0;
        bus.rx_data_in  = 8'h00;
        bus.tx_ready_in = 1'b0;

        // Reset values, asserted asynchronously before any clock edge
        #1 rst_in = 1'b1;
        #1;
        chk("reset_rdata",    bus.ram_rdata_out,   8'h00);
        chk("reset_tx_valid", bus.tx_valid_out,    1'b0);
        chk("reset_tx_data",  bus.tx_data_out,     8'h00);
        chk("reset_cpu_rdy",  bus.cpu_rdy_out,     1'b1);
        chk("reset_rx_ovf",   bus.rx_overflow_out, 1'b0);
        do_reset();

        // RAM vectors: single byte, idle read of address 0, LE word, decode aliasing
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 32'h0000_0000, 8'h3C, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h3C};
        vecs[4]  = '{1'b1, 32'h0000_0100, 8'h78, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 32'h0000_0101, 8'h56, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 32'h0000_0102, 8'h34, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 32'h0000_0103, 8'h12, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b1, 8'h78};
        vecs[9]  = '{1'b0, 32'h0000_0101, 8'h00, 1'b1, 8'h56};
        vecs[10] = '{1'b0, 32'h0000_0102, 8'h00, 1'b1, 8'h34};
        vecs[11] = '{1'b0, 32'h0000_0103, 8'h00, 1'b1, 8'h12};
        vecs[12] = '{1'b0, 32'hFFF2_0010, 8'h00, 1'b1, 8'hA5};
        vecs[13] = '{1'b1, 32'h0001_0010, 8'h5A, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 32'h0001_0010, 8'h00, 1'b1, 8'h5A};
        vecs[15] = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
        vecs[16] = '{1'b1, 32'h0003_0005, 8'h77, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 32'h0003_0005, 8'h00, 1'b1, 8'h00};
        vecs[18] = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h3C};
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            tick();
            if (vecs[i].check) chk($sformatf("vec%0d_rdata", i), bus.ram_rdata_out, vecs[i].exp);
        end
        idle();

        // TX fill to full, held write, then drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i));
            tick();
            chk($sformatf("tx_fill%0d_rdy", i), bus.cpu_rdy_out, (i < 15) ? 1'b1 : 1'b0);
        end
        drive(1'b1, 32'h0003_0000, 8'h99);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("tx_held_rdy", bus.cpu_rdy_out, 1'b0);
        end
        idle();
        bus.tx_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_drain%0d_valid", i), bus.tx_valid_out, 1'b1);
            chk($sformatf("tx_drain%0d_data", i), bus.tx_data_out, 8'(i));
            tick();
        end
        chk("tx_empty_valid", bus.tx_valid_out, 1'b0);
        chk("tx_empty_rdy", bus.cpu_rdy_out, 1'b1);
        bus.tx_ready_in = 1'b0;

        // RX overflow, status read/clear, drain
        do_reset();
        bus.rx_valid_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.rx_data_in = 8'h40 + 8'(i);
            tick();
            chk($sformatf("rx_fill%0d_ovf", i), bus.rx_overflow_out, (i == 16) ? 1'b1 : 1'b0);
        end
        bus.rx_valid_in = 1'b0;
        drive(1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("rx_status_ovf", bus.ram_rdata_out, 8'h06);
        chk("rx_ovf_cleared", bus.rx_overflow_out, 1'b0);
        drive(1'b0, 32'h0003_0000, 8'h00);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("rx_read%0d", i), bus.ram_rdata_out, (i < 16) ? 8'h40 + 8'(i) : 8'h00);
        end

        // RX full with same-edge push and pop; then drop racing a status clear
        do_reset();
        bus.rx_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.rx_data_in = 8'h80 + 8'(i);
            tick();
        end
        bus.rx_data_in = 8'hEE;
        drive(1'b0, 32'h0003_0000, 8'h00);
        tick();
        chk("rx_full_pop_head", bus.ram_rdata_out, 8'h80);
        chk("rx_full_pop_ovf", bus.rx_overflow_out, 1'b0);
        bus.rx_data_in = 8'hDD;
        drive(1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("rx_set_clr_status", bus.ram_rdata_out, 8'h02);
        chk("rx_set_wins", bus.rx_overflow_out, 1'b1);
        bus.rx_valid_in = 1'b0;
        drive(1'b0, 32'h0003_0000, 8'h00);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("rx5_read%0d", i), bus.ram_rdata_out,
                (i < 15) ? 8'h81 + 8'(i) : ((i == 15) ? 8'hEE : 8'h00));
        end
        drive(1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("rx5_status", bus.ram_rdata_out, 8'h04);
        chk("rx5_ovf_cleared", bus.rx_overflow_out, 1'b0);

        // Asynchronous reset while TX is full and the CPU is frozen
        do_reset();
        bus.rx_valid_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.rx_data_in = 8'(i);
            tick();
        end
        bus.rx_valid_in = 1'b0;
        drive(1'b0, 32'h0000_0010, 8'h00);
        tick();
        chk("rst6_pre_rdata", bus.ram_rdata_out, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h0003_0000, 8'hC0 + 8'(i));
            tick();
        end
        chk("rst6_pre_rdy", bus.cpu_rdy_out, 1'b0);
        chk("rst6_rdata_hold", bus.ram_rdata_out, 8'hA5);
        chk("rst6_pre_ovf", bus.rx_overflow_out, 1'b1);
        #3 rst_in = 1'b1;
        #1;
        chk("rst6_rdata",    bus.ram_rdata_out,   8'h00);
        chk("rst6_tx_valid", bus.tx_valid_out,    1'b0);
        chk("rst6_tx_data",  bus.tx_data_out,     8'h00);
        chk("rst6_cpu_rdy",  bus.cpu_rdy_out,     1'b1);
        chk("rst6_rx_ovf",   bus.rx_overflow_out, 1'b0);
        idle();
        tick();
        rst_in = 1'b0;
        tick();
        chk("rst6_post_tx_valid", bus.tx_valid_out, 1'b0);
        drive(1'b0, 32'h0003_0000, 8'h00);
        tick();
        chk("rst6_rx_empty", bus.ram_rdata_out, 8'h00);
        drive(1'b0, 32'h0003_0004, 8'h00);
        tick();
        chk("rst6_status", bus.ram_rdata_out, 8'h00);
        drive(1'b0, 32'h0000_0010, 8'h00);
        tick();
        chk("rst6_ram_kept", bus.ram_rdata_out, 8'hA5);

        // Randomized run against the reference model
        do_reset();
        txq.delete();
        rxq.delete();
        ram_m.delete();
        m_ovf   = 1'b0;
        m_rdata = 8'h00;
        m_known = 1'b1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            int unsigned sel;
            int unsigned pick;
            logic [31:0] addr;
            logic        rw;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                addr = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 31));
                rw   = 1'($urandom_range(0, 1));
            end else if (sel < 4) begin
                addr = 32'h0002_0000 | 32'($urandom_range(0, 31));
                rw   = 1'($urandom_range(0, 1));
            end else begin
                pick = $urandom_range(0, 3);
                addr = 32'h0003_0000 | ((pick < 2) ? 32'h0 :
                       ((pick == 2) ? 32'h4 : 32'($urandom_range(0, 7))));
                rw   = ($urandom_range(0, 9) < 6);
            end
            drive(rw, addr, 8'($urandom));
            bus.rx_valid_in = 1'($urandom_range(0, 1));
            bus.rx_data_in  = 8'($urandom);
            bus.tx_ready_in = ((cyc % 200) < 120) ? 1'b0 : 1'($urandom_range(0, 1));
            model_step();
            tick();
            chk("rnd_cpu_rdy", bus.cpu_rdy_out, (txq.size() != TxDepth));
            chk("rnd_tx_valid", bus.tx_valid_out, (txq.size() != 0));
            if (txq.size() != 0) chk("rnd_tx_data", bus.tx_data_out, txq[0]);
            chk("rnd_rx_ovf", bus.rx_overflow_out, m_ovf);
            if (m_known) chk("rnd_rdata", bus.ram_rdata_out, m_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
